// File: rtl/mem_responder_pkg.sv
// Shared address map and access decode for the memory/IO responder.
// IO space sits where address bits [17:16] are both set.
package mem_responder_pkg;

    localparam logic [31:0] IO_BASE     = 32'h0003_0000;
    localparam int          IO_SEL_HI   = 17;
    localparam int          IO_SEL_LO   = 16;
    localparam logic [1:0]  IO_SEL      = IO_BASE[IO_SEL_HI:IO_SEL_LO];
    localparam logic [15:0] IO_UART_OFF = 16'h0000;
    localparam logic [15:0] IO_STAT_OFF = 16'h0004;

    typedef enum logic [1:0] {
        ACC_RAM,
        ACC_UART,
        ACC_STAT,
        ACC_NONE
    } acc_e;

    function automatic acc_e decode_acc(input logic [IO_SEL_HI:0] addr);
        acc_e acc;
        if (addr[IO_SEL_HI:IO_SEL_LO] != IO_SEL)
            acc = ACC_RAM;
        else if (addr[IO_SEL_LO-1:0] == IO_UART_OFF)
            acc = ACC_UART;
        else if (addr[IO_SEL_LO-1:0] == IO_STAT_OFF)
            acc = ACC_STAT;
        else
            acc = ACC_NONE;
        return acc;
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Allocator-side memory bus plus UART TX/RX handshakes.
// master = allocator/UART side, slave = mem_responder.
interface mem_responder_if;

    logic [31:0] mem_a_in;
    logic [7:0]  mem_d_in;
    logic        mem_wr_in;
    logic [7:0]  mem_d_out;
    logic        io_buffer_full_out;
    logic        tx_valid_out;
    logic [7:0]  tx_data_out;
    logic        tx_ready_in;
    logic        rx_valid_in;
    logic [7:0]  rx_data_in;
    logic        rx_ready_out;
    logic        sim_end_out;
    logic        tx_overflow_out;

    modport master (
        output mem_a_in, mem_d_in, mem_wr_in,
        output tx_ready_in, rx_valid_in, rx_data_in,
        input  mem_d_out, io_buffer_full_out,
        input  tx_valid_out, tx_data_out,
        input  rx_ready_out, sim_end_out, tx_overflow_out
    );

    modport slave (
        input  mem_a_in, mem_d_in, mem_wr_in,
        input  tx_ready_in, rx_valid_in, rx_data_in,
        output mem_d_out, io_buffer_full_out,
        output tx_valid_out, tx_data_out,
        output rx_ready_out, sim_end_out, tx_overflow_out
    );

endinterface

// File: rtl/mem_responder_io_fifo.sv
// Byte FIFO for UART transmit; near_full is registered from the
// post-update count so the allocator sees it one cycle ahead.
module io_fifo #(
    parameter  int DEPTH  = 8,
    parameter  int MARGIN = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = AW + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          en,
    input  logic          push,
    input  logic [7:0]    push_data,
    input  logic          pop_ready,
    output logic [7:0]    head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          near_full
);

    logic [7:0]    slots [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_next;
    logic          pop;
    logic          put;

    assign full = (count == CW'(DEPTH));
    assign head = slots[rd_ptr];
    assign pop  = en && !rst_in && (count != '0) && pop_ready;
    // a pop in the same cycle frees the slot the push lands in
    assign put  = en && !rst_in && push && (!full || pop);

    always_comb begin
        count_next = count;
        unique case ({put, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            near_full <= 1'b0;
        end else begin
            if (put)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            count     <= count_next;
            near_full <= (count_next >= CW'(DEPTH - MARGIN));
        end
    end

    always_ff @(posedge clk_in) begin
        if (put)
            slots[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/mem_responder.sv
// Byte RAM plus memory-mapped UART/status IO behind the allocator bus.
// Reads are registered (1-cycle latency); rdy_in low freezes everything.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int TX_DEPTH       = 8,
    parameter int FULL_MARGIN    = 2
) (
    input logic              clk_in,
    input logic              rst_in,
    input logic              rdy_in,
    mem_responder_if.slave   bus
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [7:0]                ram [2**RAM_ADDR_WIDTH];
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    acc_e                      acc;
    logic                      go;
    logic                      ram_we;
    logic                      tx_push;
    logic                      tx_pop;
    logic                      tx_drop;
    logic                      uart_rd;
    logic                      rx_load;
    logic                      rx_full;
    logic [7:0]                rx_data;
    logic [7:0]                rd_next;
    logic [7:0]                dout;
    logic                      overflow;
    logic [7:0]                tx_head;
    logic [CW-1:0]             tx_count;
    logic                      tx_full;
    logic                      near_full;
    logic                      tx_valid;
    logic                      unused_addr_hi;

    // bits above the IO select never take part in decode
    assign unused_addr_hi = ^bus.mem_a_in[31:IO_SEL_HI+1];

    assign acc      = decode_acc(bus.mem_a_in[IO_SEL_HI:0]);
    assign ram_addr = bus.mem_a_in[RAM_ADDR_WIDTH-1:0];
    assign go       = rdy_in && !rst_in;
    assign ram_we   = go && bus.mem_wr_in && (acc == ACC_RAM);
    assign tx_push  = bus.mem_wr_in && (acc == ACC_UART);
    assign uart_rd  = go && !bus.mem_wr_in && (acc == ACC_UART);
    assign rx_load  = go && bus.rx_valid_in && !rx_full;
    assign tx_valid = (tx_count != '0);
    assign tx_pop   = go && tx_valid && bus.tx_ready_in;
    assign tx_drop  = go && tx_push && tx_full && !tx_pop;

    always_ff @(posedge clk_in) begin
        if (ram_we)
            ram[ram_addr] <= bus.mem_d_in;
    end

    always_comb begin
        rd_next = 8'h00;
        if (!bus.mem_wr_in) begin
            unique case (acc)
                ACC_RAM:  rd_next = ram[ram_addr];
                ACC_UART: rd_next = rx_full ? rx_data : 8'h00;
                ACC_STAT: rd_next = {6'b0, rx_full, near_full};
                default:  rd_next = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            dout     <= 8'h00;
            rx_full  <= 1'b0;
            rx_data  <= 8'h00;
            overflow <= 1'b0;
        end else if (rdy_in) begin
            dout <= rd_next;
            // a load only happens into an empty holder, so it wins over the read
            if (rx_load) begin
                rx_full <= 1'b1;
                rx_data <= bus.rx_data_in;
            end else if (uart_rd) begin
                rx_full <= 1'b0;
            end
            if (tx_drop)
                overflow <= 1'b1;
        end
    end

    io_fifo #(
        .DEPTH     (TX_DEPTH),
        .MARGIN    (FULL_MARGIN)
    ) u_tx_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .en        (rdy_in),
        .push      (tx_push),
        .push_data (bus.mem_d_in),
        .pop_ready (bus.tx_ready_in),
        .head      (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .near_full (near_full)
    );

    assign bus.mem_d_out          = dout;
    assign bus.io_buffer_full_out = near_full;
    assign bus.tx_valid_out       = tx_valid;
    assign bus.tx_data_out        = tx_head;
    assign bus.tx_overflow_out    = overflow;
    assign bus.rx_ready_out       = !rx_full;
    assign bus.sim_end_out        = go && bus.mem_wr_in && (acc == ACC_STAT);

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random traffic,
// checked every cycle against a queue/array model of the address map.
module tb_mem_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;

    mem_responder_if bus ();

    mem_responder #(
        .RAM_ADDR_WIDTH (17),
        .TX_DEPTH       (DEPTH),
        .FULL_MARGIN    (MARGIN)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .rdy_in (rdy),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    byte unsigned ram_m [int];
    logic [7:0]   txq [$];
    bit           m_ovf, m_full, m_rxv, m_known, checking, rx_taken;
    logic [7:0]   m_rxd, m_dout;
    int           sim_pulses;
    logic         tx_rdy_d, rx_v_d;
    logic [7:0]   rx_d_d;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        chk("tx_valid", bus.tx_valid_out, txq.size() != 0);
        if (txq.size() != 0)
            chk("tx_data", bus.tx_data_out, txq[0]);
        chk("io_full", bus.io_buffer_full_out, m_full);
        chk("overflow", bus.tx_overflow_out, m_ovf);
        chk("rx_ready", bus.rx_ready_out, !m_rxv);
        if (m_known)
            chk("mem_d_out", bus.mem_d_out, m_dout);
    endtask

    // One clock: apply inputs, predict, then compare after the edge.
    task automatic step(input bit r, input bit y, input logic [31:0] a,
                        input logic [7:0] d, input bit w);
        bit          io, pop, exp_end;
        logic [15:0] off;
        int          idx;
        rst = r;
        rdy = y;
        bus.mem_a_in    = a;
        bus.mem_d_in    = d;
        bus.mem_wr_in   = w;
        bus.tx_ready_in = tx_rdy_d;
        bus.rx_valid_in = rx_v_d;
        bus.rx_data_in  = rx_d_d;
        #1;
        io  = (a[17:16] == 2'b11);
        off = a[15:0];
        idx = int'(a & 32'h0001_FFFF);
        exp_end = !r && y && w && io && (off == 16'h4);
        if (checking)
            chk("sim_end", bus.sim_end_out, exp_end);
        if (bus.sim_end_out)
            sim_pulses++;
        rx_taken = 1'b0;
        if (r) begin
            txq.delete();
            m_ovf = 0; m_full = 0; m_rxv = 0;
            m_dout = 8'h00; m_known = 1;
        end else if (y) begin
            pop = (txq.size() != 0) && tx_rdy_d;
            m_known = 1;
            if (w)
                m_known = 0;
            else if (!io) begin
                if (ram_m.exists(idx)) m_dout = ram_m[idx];
                else m_known = 0;
            end else if (off == 16'h0)
                m_dout = m_rxv ? m_rxd : 8'h00;
            else if (off == 16'h4)
                m_dout = {6'b0, m_rxv, m_full};
            else
                m_dout = 8'h00;
            if (pop)
                void'(txq.pop_front());
            if (w && io && off == 16'h0) begin
                if (txq.size() < DEPTH) txq.push_back(d);
                else m_ovf = 1;
            end
            if (w && !io)
                ram_m[idx] = d;
            if (rx_v_d && !m_rxv) begin
                m_rxv = 1; m_rxd = rx_d_d; rx_taken = 1;
            end else if (!w && io && off == 16'h0)
                m_rxv = 0;
            m_full = (txq.size() >= DEPTH - MARGIN);
        end
        @(negedge clk);
        if (checking)
            check_outputs();
    endtask

    task automatic wr(input logic [31:0] a, input logic [7:0] d);
        step(0, 1, a, d, 1);
    endtask

    task automatic rd(input logic [31:0] a);
        step(0, 1, a, 8'h00, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not end");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0]  vals  [4];
        logic [7:0]  order [8];
        bit          y, r, w;
        int          k;
        logic [31:0] a;
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        order = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5, 8'hD6, 8'hD7, 8'hC9};
        tx_rdy_d = 0; rx_v_d = 0; rx_d_d = 8'h00;
        sim_pulses = 0;
        bus.mem_a_in = '0; bus.mem_d_in = '0; bus.mem_wr_in = 0;
        bus.tx_ready_in = 0; bus.rx_valid_in = 0; bus.rx_data_in = '0;
        @(negedge clk);
        step(1, 1, 0, 0, 0);
        checking = 1;
        step(1, 1, 0, 0, 0);
        chk("rst_dout", bus.mem_d_out, 8'h00);
        chk("rst_tx_valid", bus.tx_valid_out, 1'b0);
        chk("rst_rx_ready", bus.rx_ready_out, 1'b1);
        chk("rst_full", bus.io_buffer_full_out, 1'b0);
        chk("rst_ovf", bus.tx_overflow_out, 1'b0);

        wr(32'h10, 8'hA5);
        rd(32'h10);
        chk("ram_a5", bus.mem_d_out, 8'hA5);

        for (int i = 0; i < 4; i++)
            wr(32'h100 + i, vals[i]);
        for (int i = 0; i < 4; i++) begin
            rd(32'h100 + i);
            chk("ram_burst", bus.mem_d_out, vals[i]);
        end

        tx_rdy_d = 0;
        for (int i = 0; i < 9; i++) begin
            wr(32'h30000, 8'hD0 + 8'(i));
            if (i == 4) chk("full_before_6", bus.io_buffer_full_out, 1'b0);
            if (i == 5) chk("full_after_6", bus.io_buffer_full_out, 1'b1);
            if (i == 7) chk("ovf_at_8", bus.tx_overflow_out, 1'b0);
        end
        chk("ovf_set", bus.tx_overflow_out, 1'b1);
        chk("tx_head", bus.tx_data_out, 8'hD0);

        tx_rdy_d = 1;
        wr(32'h30000, 8'hC9);
        chk("full_pushpop_head", bus.tx_data_out, 8'hD1);
        chk("full_pushpop_nf", bus.io_buffer_full_out, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", bus.tx_data_out, order[i]);
            rd(32'h0);
        end
        chk("drained", bus.tx_valid_out, 1'b0);
        step(1, 1, 0, 0, 0);
        chk("ovf_cleared", bus.tx_overflow_out, 1'b0);

        rx_v_d = 1; rx_d_d = 8'h5A;
        rd(32'h0);
        rx_v_d = 0;
        chk("rx_held", bus.rx_ready_out, 1'b0);
        rd(32'h30004);
        chk("status", bus.mem_d_out, 8'h02);
        rd(32'h30000);
        chk("rx_5a", bus.mem_d_out, 8'h5A);
        rd(32'h30000);
        chk("rx_empty", bus.mem_d_out, 8'h00);
        chk("rx_ready_again", bus.rx_ready_out, 1'b1);

        rx_v_d = 1; rx_d_d = 8'h77;
        rd(32'h30000);
        rx_v_d = 0;
        chk("rx_same_cycle_old", bus.mem_d_out, 8'h00);
        rd(32'h30000);
        chk("rx_same_cycle_new", bus.mem_d_out, 8'h77);
        wr(32'h30008, 8'h55);
        rd(32'h30008);
        chk("io_other", bus.mem_d_out, 8'h00);
        chk("io_other_nopush", bus.tx_valid_out, 1'b0);

        sim_pulses = 0;
        step(0, 0, 32'h30004, 0, 1);
        step(0, 1, 32'h30004, 0, 1);
        step(0, 0, 32'h30004, 0, 1);
        step(0, 1, 32'h0, 0, 0);
        chk("sim_end_pulses", sim_pulses, 1);

        tx_rdy_d = 0;
        wr(32'h200, 8'h3C);
        wr(32'h30000, 8'hAA);
        wr(32'h30000, 8'hBB);
        step(1, 1, 32'h200, 8'h99, 1);
        rd(32'h200);
        chk("ram_kept", bus.mem_d_out, 8'h3C);
        chk("fifo_flushed", bus.tx_valid_out, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            y = ($urandom_range(99) < 85);
            r = ($urandom_range(499) == 0);
            tx_rdy_d = ((n / 200) % 2 == 1) ? ($urandom_range(99) < 70)
                                            : ($urandom_range(99) < 15);
            if (rx_taken) rx_v_d = 0;
            if (!rx_v_d && $urandom_range(3) == 0) begin
                rx_v_d = 1;
                rx_d_d = 8'($urandom);
            end
            k = $urandom_range(9);
            if (k <= 3) begin
                a = 32'($urandom_range(63));
                if (k == 3) a = a | 32'h0002_0000;
            end else if (k == 4) a = 32'h0;
            else if (k <= 6) a = 32'h30000;
            else if (k == 7) a = 32'h30004;
            else if (k == 8) a = 32'h30008;
            else a = 32'h3FF00;
            w = ($urandom_range(1) == 1);
            step(r, y, a, 8'($urandom), w);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
